painterengine_gpu_dma_reader: RTL and testbench
===============================================

PAINTERENGINE_GPU_DMA_READER -- requirements
Module: painterengine_gpu_dma_reader

Interface
REQ-001 SHALL have parameter: P_TIMEOUT_CYCLES, 1024, max cycles waiting on a single AR or R handshake before timeout error.
REQ-002 SHALL have ports: i_wire_clock  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: i_wire_resetn  in  1  synchronous, active-low reset; release doubles as transfer start.
REQ-004 SHALL have ports: i_wire_address  in  32  source byte address; i_wire_length  in  32  transfer length in 32-bit words.
REQ-005 SHALL have ports: o_wire_done  out  1  transfer complete; o_wire_error  out  1  transfer failed.
REQ-006 SHALL have ports: o_wire_m_axi_araddr out 32; o_wire_m_axi_arvalid out 1; i_wire_m_axi_arready in 1 (single-beat read address channel).
REQ-007 SHALL have ports: i_wire_m_axi_rdata in 32; i_wire_m_axi_rresp in 2; i_wire_m_axi_rvalid in 1; o_wire_m_axi_rready out 1.
REQ-008 SHALL have ports: o_wire_fifo_write_enable out 1; o_wire_fifo_write_data out 32; i_wire_fifo_full in 1.
REQ-009 SHALL have ports: o_wire_state  out  32  {24'd0, state code}.

Function
REQ-010 SHALL use states INIT=8'h00, ADDR=8'h01, DATA=8'h02, DONE=8'h03, ERROR_RESP=8'h04, ERROR_ALIGN=8'h05, ERROR_TIMEOUT=8'h06.
REQ-011 INIT (first cycle with resetn high): SHALL latch address to current address, length to remaining count; length 0 -> DONE; else -> ADDR.
REQ-012 ADDR: arvalid=1, araddr=current address; on arvalid&&arready SHALL go to DATA, arvalid low next cycle.
REQ-013 DATA: rready SHALL equal !i_wire_fifo_full combinationally.
REQ-014 On rvalid&&rready with rresp==2'b00: fifo_write_enable=1 same cycle, write_data=rdata, address+=4, remaining-=1; remaining was 1 -> DONE, else -> ADDR.
REQ-015 On rvalid&&rready with rresp!=0: SHALL NOT push; -> ERROR_RESP.
REQ-016 fifo_write_enable SHALL be 0 in every state and cycle except REQ-014.
REQ-017 Address arithmetic SHALL be 32-bit modulo 2^32 (wrap from 32'hFFFFFFFC to 0 permitted, no error).
REQ-018 Timeout counter SHALL clear on state entry and every handshake, increment each cycle in ADDR, and in DATA only while fifo not full; reaching P_TIMEOUT_CYCLES -> ERROR_TIMEOUT, arvalid/rready dropped.
REQ-019 o_wire_done SHALL be 1 exactly in DONE; o_wire_error SHALL be 1 in any ERROR_* state; both are state decodes, sticky until reset.
REQ-020 DONE and ERROR_* SHALL be terminal; only resetn low leaves them.
REQ-021 Maximum throughput SHALL be one word per 2 cycles (AR then R, no outstanding overlap).

Reset
REQ-022 resetn low at any rising edge SHALL force next cycle: state INIT, arvalid 0, rready 0, fifo_write_enable 0, araddr 0, done 0, error 0, counters 0.
REQ-023 Reset mid-transfer SHALL abandon in-flight transaction; no FIFO write on the reset cycle.
REQ-024 While resetn low, inputs address/length SHALL be ignored.

Configuration
REQ-025 GPU_DMA_READER_ALIGN_CHECK_EN defined: in INIT, address[1:0]!=0 SHALL go to ERROR_ALIGN with no AR issued (takes priority over length 0).
REQ-026 GPU_DMA_READER_ALIGN_CHECK_EN undefined: ERROR_ALIGN unreachable; araddr SHALL be issued with low two bits forced to 0.

Structure
REQ-027 State codes and AXI response constant OKAY=2'b00 SHALL live in shared package painterengine_gpu_pkg.
REQ-028 No sub-module; timeout counter inline.

Verification
REQ-029 addr=0x1000, len=4, arready/rvalid immediate, rresp 0 -> 4 pushes of data at 0x1000..0x100C, done=1, state=0x03 after ~9 cycles.
REQ-030 len=0 -> done=1 on second cycle after reset release, zero arvalid, zero pushes.
REQ-031 len=3, fifo_full held 1 for 2000 cycles during word 2 -> rready 0, no timeout, completes after full drops, 3 pushes.
REQ-032 len=2, second rresp=2'b10 -> 1 push, error=1, state=0x04, done=0.
REQ-033 arready held 0 -> error=1, state=0x06 after 1024 cycles in ADDR; reset mid-transfer of len=8 at word 3 -> all outputs reset next cycle, restart rereads from new address.
REQ-034 With GPU_DMA_READER_ALIGN_CHECK_EN, addr=0x1002 -> state=0x05, no arvalid; without it, araddr=0x1000.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// Shared GPU constants: DMA reader state codes and AXI response encodings.
package painterengine_gpu_pkg;

    typedef enum logic [7:0] {
        ST_INIT          = 8'h00,
        ST_ADDR          = 8'h01,
        ST_DATA          = 8'h02,
        ST_DONE          = 8'h03,
        ST_ERROR_RESP    = 8'h04,
        ST_ERROR_ALIGN   = 8'h05,
        ST_ERROR_TIMEOUT = 8'h06
    } dma_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic is_error_state(input dma_state_e s);
        return (s == ST_ERROR_RESP) || (s == ST_ERROR_ALIGN) || (s == ST_ERROR_TIMEOUT);
    endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader_if.sv
// AXI read (single-beat AR/R) and FIFO push signals of the GPU DMA reader.
interface painterengine_gpu_dma_reader_if;
    import painterengine_gpu_pkg::*;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        fifo_write_enable;
    logic [31:0] fifo_write_data;
    logic        fifo_full;

    // The reader side drives AR, R-ready and the FIFO push.
    modport master (
        output araddr, arvalid, rready, fifo_write_enable, fifo_write_data,
        input  arready, rdata, rresp, rvalid, fifo_full
    );

    modport slave (
        input  araddr, arvalid, rready, fifo_write_enable, fifo_write_data,
        output arready, rdata, rresp, rvalid, fifo_full
    );

endinterface

// File: rtl/painterengine_gpu_dma_reader.sv
// Single-beat AXI read DMA pushing 32-bit words into a FIFO; a transfer starts on reset release.
// Optional GPU_DMA_READER_ALIGN_CHECK_EN rejects unaligned start addresses instead of masking them.
module painterengine_gpu_dma_reader
    import painterengine_gpu_pkg::*;
#(
    parameter int P_TIMEOUT_CYCLES = 1024
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [31:0] o_wire_m_axi_araddr,
    output logic        o_wire_m_axi_arvalid,
    input  logic        i_wire_m_axi_arready,
    input  logic [31:0] i_wire_m_axi_rdata,
    input  logic [1:0]  i_wire_m_axi_rresp,
    input  logic        i_wire_m_axi_rvalid,
    output logic        o_wire_m_axi_rready,
    output logic        o_wire_fifo_write_enable,
    output logic [31:0] o_wire_fifo_write_data,
    input  logic        i_wire_fifo_full,
    output logic [31:0] o_wire_state
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(P_TIMEOUT_CYCLES - 1);

    dma_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] timeout_q, timeout_d;
    logic        arvalid_c, rready_c, push_c;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            state_q     <= ST_INIT;
            addr_q      <= '0;
            remaining_q <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        timeout_d   = timeout_q;
        arvalid_c   = 1'b0;
        rready_c    = 1'b0;
        push_c      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                addr_d      = i_wire_address;
                remaining_d = i_wire_length;
`ifdef GPU_DMA_READER_ALIGN_CHECK_EN
                if (i_wire_address[1:0] != 2'b00) begin
                    state_d = ST_ERROR_ALIGN;
                end else if (i_wire_length == 32'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADDR;
                end
`else
                if (i_wire_length == 32'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADDR;
                end
`endif
            end

            ST_ADDR: begin
                arvalid_c = 1'b1;
                if (i_wire_m_axi_arready) begin
                    state_d = ST_DATA;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = ST_ERROR_TIMEOUT;
                end else begin
                    timeout_d = timeout_q + 32'd1;
                end
            end

            ST_DATA: begin
                rready_c = !i_wire_fifo_full;
                if (i_wire_m_axi_rvalid && rready_c) begin
                    if (i_wire_m_axi_rresp == AXI_RESP_OKAY) begin
                        push_c      = 1'b1;
                        addr_d      = addr_q + 32'd4;
                        remaining_d = remaining_q - 32'd1;
                        state_d     = (remaining_q == 32'd1) ? ST_DONE : ST_ADDR;
                    end else begin
                        state_d = ST_ERROR_RESP;
                    end
                end else if (!i_wire_fifo_full) begin
                    // A full FIFO is back-pressure, not a stalled slave: the count freezes.
                    if (timeout_q == TIMEOUT_LAST) begin
                        state_d = ST_ERROR_TIMEOUT;
                    end else begin
                        timeout_d = timeout_q + 32'd1;
                    end
                end
            end

            default: ;
        endcase

        // Each handshake also changes state, so this one clear covers both cases.
        if (state_d != state_q) begin
            timeout_d = '0;
        end
    end

`ifdef GPU_DMA_READER_ALIGN_CHECK_EN
    assign o_wire_m_axi_araddr = addr_q;
`else
    assign o_wire_m_axi_araddr = addr_q & 32'hFFFF_FFFC;
`endif

    assign o_wire_m_axi_arvalid = arvalid_c;
    assign o_wire_m_axi_rready  = rready_c;
    // Gated by reset so an abandoned beat is never pushed on the reset edge.
    assign o_wire_fifo_write_enable = push_c && i_wire_resetn;
    assign o_wire_fifo_write_data   = i_wire_m_axi_rdata;
    assign o_wire_done  = (state_q == ST_DONE);
    assign o_wire_error = is_error_state(state_q);
    assign o_wire_state = {24'd0, state_q};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader; a negedge process models the AXI slave and logs FIFO pushes.
module tb_painterengine_gpu_dma_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] length = '0;
    logic        done, error;
    logic [31:0] state;

    painterengine_gpu_dma_reader_if bus();

    painterengine_gpu_dma_reader dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (resetn),
        .i_wire_address           (address),
        .i_wire_length            (length),
        .o_wire_done              (done),
        .o_wire_error             (error),
        .o_wire_m_axi_araddr      (bus.araddr),
        .o_wire_m_axi_arvalid     (bus.arvalid),
        .i_wire_m_axi_arready     (bus.arready),
        .i_wire_m_axi_rdata       (bus.rdata),
        .i_wire_m_axi_rresp       (bus.rresp),
        .i_wire_m_axi_rvalid      (bus.rvalid),
        .o_wire_m_axi_rready      (bus.rready),
        .o_wire_fifo_write_enable (bus.fifo_write_enable),
        .o_wire_fifo_write_data   (bus.fifo_write_data),
        .i_wire_fifo_full         (bus.fifo_full),
        .o_wire_state             (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave memory contents: every word is its address scrambled by a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    logic [31:0] push_log [256];
    logic [31:0] ar_log [256];
    int          push_cnt = 0;
    int          ar_cnt = 0;
    int          arvalid_cycles = 0;
    int          ar_base = 0;
    int          err_word = -1;
    logic [31:0] rsp_data = '0;
    logic [1:0]  rsp_resp = 2'b00;

    assign bus.rdata = rsp_data;
    assign bus.rresp = rsp_resp;

    always @(negedge clk) begin
        if (bus.fifo_write_enable) begin
            push_log[push_cnt] = bus.fifo_write_data;
            push_cnt++;
        end
        if (bus.arvalid) arvalid_cycles++;
        if (bus.arvalid && bus.arready) begin
            ar_log[ar_cnt] = bus.araddr;
            rsp_data = mem_word(bus.araddr);
            rsp_resp = ((ar_cnt - ar_base) == err_word) ? 2'b10 : 2'b00;
            ar_cnt++;
        end
    end

    int push_base, arv_base;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Holds reset for two cycles, then releases it; the next rising edge is the INIT cycle.
    task automatic start(input logic [31:0] a, input logic [31:0] l);
        resetn = 1'b0;
        address = 32'hDEAD_BEEF;
        length = 32'hFFFF_FFFF;
        tick();
        address = a;
        length = l;
        tick();
        push_base = push_cnt;
        arv_base = arvalid_cycles;
        ar_base = ar_cnt;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (state !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", state, 32'h0);
        end
        n_cmp++;
        if ({done, error, bus.arvalid, bus.rready, bus.fifo_write_enable} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000",
                {done, error, bus.arvalid, bus.rready, bus.fifo_write_enable});
        end
        n_cmp++;
        if (bus.araddr !== 32'h0) begin
            n_fail++; $display("FAIL reset_araddr: got %h want 0", bus.araddr);
        end
    endtask

    task automatic test_basic();
        start(32'h1000, 32'd4);
        repeat (8) tick();
        n_cmp++;
        if (state !== 32'h2 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_last_data: state %h done %b want 02/0", state, done);
        end
        tick();
        n_cmp++;
        if (state !== 32'h3 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: state %h done %b error %b want 03/1/0", state, done, error);
        end
        n_cmp++;
        if (push_cnt - push_base !== 4) begin
            n_fail++; $display("FAIL basic_push_count: got %0d want 4", push_cnt - push_base);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (push_log[push_base + i] !== mem_word(32'h1000 + 32'(4 * i))) begin
                n_fail++; $display("FAIL basic_data%0d: got %h want %h", i,
                    push_log[push_base + i], mem_word(32'h1000 + 32'(4 * i)));
            end
        end
        repeat (3) tick();
        n_cmp++;
        if (state !== 32'h3 || push_cnt - push_base !== 4) begin
            n_fail++; $display("FAIL basic_sticky: state %h pushes %0d want 03/4", state, push_cnt - push_base);
        end
    endtask

    task automatic test_len_zero();
        start(32'h4000, 32'd0);
        tick();
        n_cmp++;
        if (done !== 1'b1 || state !== 32'h3) begin
            n_fail++; $display("FAIL len0_done: done %b state %h want 1/03", done, state);
        end
        repeat (5) tick();
        n_cmp++;
        if (arvalid_cycles - arv_base !== 0 || push_cnt - push_base !== 0) begin
            n_fail++; $display("FAIL len0_idle: arvalid cycles %0d pushes %0d want 0/0",
                arvalid_cycles - arv_base, push_cnt - push_base);
        end
    endtask

    task automatic test_fifo_full();
        start(32'h6000, 32'd3);
        for (int n = 0; n < 20 && (push_cnt - push_base) < 1; n++) tick();
        bus.fifo_full = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (state !== 32'h2 || bus.rready !== 1'b0 || bus.fifo_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL full_stall: state %h rready %b we %b want 02/0/0",
                state, bus.rready, bus.fifo_write_enable);
        end
        repeat (1990) tick();
        n_cmp++;
        if (state !== 32'h2 || error !== 1'b0 || push_cnt - push_base !== 1) begin
            n_fail++; $display("FAIL full_no_timeout: state %h error %b pushes %0d want 02/0/1",
                state, error, push_cnt - push_base);
        end
        bus.fifo_full = 1'b0;
        #1;
        n_cmp++;
        if (bus.rready !== 1'b1) begin
            n_fail++; $display("FAIL full_release_rready: got %b want 1", bus.rready);
        end
        for (int n = 0; n < 20 && !(done || error); n++) tick();
        n_cmp++;
        if (done !== 1'b1 || push_cnt - push_base !== 3) begin
            n_fail++; $display("FAIL full_complete: done %b pushes %0d want 1/3", done, push_cnt - push_base);
        end
        n_cmp++;
        if (push_log[push_base + 2] !== mem_word(32'h6008)) begin
            n_fail++; $display("FAIL full_data2: got %h want %h", push_log[push_base + 2], mem_word(32'h6008));
        end
    endtask

    task automatic test_resp_error();
        err_word = 1;
        start(32'h7000, 32'd2);
        for (int n = 0; n < 20 && !(done || error); n++) tick();
        n_cmp++;
        if (state !== 32'h4 || error !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL resp_err_state: state %h error %b done %b want 04/1/0", state, error, done);
        end
        n_cmp++;
        if (push_cnt - push_base !== 1 || push_log[push_base] !== mem_word(32'h7000)) begin
            n_fail++; $display("FAIL resp_err_push: pushes %0d data %h want 1/%h",
                push_cnt - push_base, push_log[push_base], mem_word(32'h7000));
        end
        err_word = -1;
    endtask

    task automatic test_timeout();
        bus.arready = 1'b0;
        start(32'h2000, 32'd4);
        repeat (1024) tick();
        n_cmp++;
        if (state !== 32'h1 || error !== 1'b0 || bus.arvalid !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: state %h error %b arvalid %b want 01/0/1",
                state, error, bus.arvalid);
        end
        tick();
        n_cmp++;
        if (state !== 32'h6 || error !== 1'b1 || done !== 1'b0 || bus.arvalid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_hit: state %h error %b done %b arvalid %b want 06/1/0/0",
                state, error, done, bus.arvalid);
        end
        bus.arready = 1'b1;
    endtask

    task automatic test_reset_mid();
        start(32'h3000, 32'd8);
        for (int n = 0; n < 40 && !((push_cnt - push_base) == 2 && state == 32'h2); n++) tick();
        n_cmp++;
        if (state !== 32'h2 || push_cnt - push_base !== 2) begin
            n_fail++; $display("FAIL midreset_reached: state %h pushes %0d want 02/2", state, push_cnt - push_base);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.fifo_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_push: we %b want 0", bus.fifo_write_enable);
        end
        tick();
        n_cmp++;
        if (state !== 32'h0 || {done, error, bus.arvalid, bus.rready} !== 4'b0 || bus.araddr !== 32'h0) begin
            n_fail++; $display("FAIL midreset_cleared: state %h flags %b araddr %h want 00/0000/0",
                state, {done, error, bus.arvalid, bus.rready}, bus.araddr);
        end
        n_cmp++;
        if (push_cnt - push_base !== 2) begin
            n_fail++; $display("FAIL midreset_push_count: got %0d want 2", push_cnt - push_base);
        end
        start(32'h5000, 32'd2);
        for (int n = 0; n < 20 && !(done || error); n++) tick();
        n_cmp++;
        if (done !== 1'b1 || push_cnt - push_base !== 2 || ar_log[ar_base] !== 32'h5000 ||
            ar_log[ar_base + 1] !== 32'h5004) begin
            n_fail++; $display("FAIL restart: done %b pushes %0d ar0 %h ar1 %h want 1/2/5000/5004",
                done, push_cnt - push_base, ar_log[ar_base], ar_log[ar_base + 1]);
        end
        n_cmp++;
        if (push_log[push_base + 1] !== mem_word(32'h5004)) begin
            n_fail++; $display("FAIL restart_data: got %h want %h", push_log[push_base + 1], mem_word(32'h5004));
        end
    endtask

    task automatic test_wrap();
        start(32'hFFFF_FFF8, 32'd3);
        for (int n = 0; n < 20 && !(done || error); n++) tick();
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL wrap_done: done %b error %b want 1/0", done, error);
        end
        n_cmp++;
        if (ar_log[ar_base] !== 32'hFFFF_FFF8 || ar_log[ar_base + 1] !== 32'hFFFF_FFFC ||
            ar_log[ar_base + 2] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addrs: got %h %h %h want fffffff8 fffffffc 00000000",
                ar_log[ar_base], ar_log[ar_base + 1], ar_log[ar_base + 2]);
        end
    endtask

    task automatic test_align();
        start(32'h1002, 32'd1);
`ifdef GPU_DMA_READER_ALIGN_CHECK_EN
        tick();
        n_cmp++;
        if (state !== 32'h5 || error !== 1'b1) begin
            n_fail++; $display("FAIL align_error: state %h error %b want 05/1", state, error);
        end
        repeat (3) tick();
        n_cmp++;
        if (arvalid_cycles - arv_base !== 0 || push_cnt - push_base !== 0) begin
            n_fail++; $display("FAIL align_no_ar: arvalid cycles %0d pushes %0d want 0/0",
                arvalid_cycles - arv_base, push_cnt - push_base);
        end
`else
        for (int n = 0; n < 20 && !(done || error); n++) tick();
        n_cmp++;
        if (ar_log[ar_base] !== 32'h1000 || state !== 32'h3) begin
            n_fail++; $display("FAIL align_mask: araddr %h state %h want 1000/03", ar_log[ar_base], state);
        end
        n_cmp++;
        if (push_cnt - push_base !== 1 || push_log[push_base] !== mem_word(32'h1000)) begin
            n_fail++; $display("FAIL align_data: pushes %0d data %h want 1/%h",
                push_cnt - push_base, push_log[push_base], mem_word(32'h1000));
        end
`endif
    endtask

    initial begin
        bus.arready = 1'b1;
        bus.rvalid = 1'b1;
        bus.fifo_full = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_fifo_full();
        test_resp_error();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
